bus_writeback: RTL and testbench

- Sink side of the CPU operand bus: captures the 8-bit b_bus value into a destination chosen by d_sel.
- Destinations are the B register (feeds the operand mux as b_reg), the A register, a discard slot, or an external output port.
- The external output port is a 2-entry valid/ready buffer, the outbound counterpart of the ext_data input. A stall output back-pressures the sequencer.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/ext_out_skid.sv | 81 ++++++++
 rtl/bus_writeback.sv | 71 +++++++
 tb/tb_bus_writeback.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the operand-bus writeback path.
package bus_pkg;

    // Default bus and register width.
    localparam int BUS_DATA_W = 8;

    // Writeback destination selected by d_sel.
    typedef enum logic [1:0] {
        DSEL_BREG = 2'b00,
        DSEL_AREG = 2'b01,
        DSEL_NONE = 2'b10,
        DSEL_EXT  = 2'b11
    } dsel_t;

    // Occupancy of the 2-entry external output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } extbuf_state_t;

endpackage

// File: rtl/ext_out_skid.sv
// Two-entry (head + skid) output buffer with valid/ready handshake.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. Once valid is high, data and valid hold steady until that
// transfer happens. full depends only on the state register, never on ready.
// A push request arriving while full is ignored (even with a same-cycle pop).
module ext_out_skid
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              full
);

    extbuf_state_t     state, state_n;
    logic [DATA_W-1:0] head, head_n;
    logic [DATA_W-1:0] skid, skid_n;
    logic              pop;
    logic              accept;

    assign valid  = (state != EMPTY);
    assign full   = (state == FULL);
    assign data   = head;
    assign pop    = valid & ready;
    assign accept = push & (state != FULL);

    // State and storage registers; reset discards any pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_n;
            head  <= head_n;
            skid  <= skid_n;
        end
    end

    // Next-state and storage update; the head always holds the oldest entry.
    always_comb begin
        state_n = state;
        head_n  = head;
        skid_n  = skid;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_n = ONE;
                    head_n  = push_data;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_n = FULL;
                    skid_n  = push_data;
                end else if (!accept && pop) begin
                    state_n = EMPTY;
                end else if (accept && pop) begin
                    head_n  = push_data;
                end
            end
            FULL: begin
                if (pop) begin
                    state_n = ONE;
                    head_n  = skid;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/bus_writeback.sv
// Operand-bus sink: writes b_bus into the B register, the A register,
// nowhere, or the external output buffer, as chosen by d_sel.
// Optional macro BUS_WRITEBACK_OVF_CNT_EN adds a saturating ovf_cnt output
// counting pushes dropped because the external buffer was full.
module bus_writeback
    import bus_pkg::*;
#(
    parameter int              DATA_W  = BUS_DATA_W,
    parameter logic [DATA_W-1:0] REG_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] b_bus,
    input  logic              wr_en,
    input  logic [1:0]        d_sel,
    output logic [DATA_W-1:0] b_reg,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic              stall
`ifdef BUS_WRITEBACK_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    dsel_t dsel;
    logic  ext_push;
    logic  ext_full;

    assign dsel     = dsel_t'(d_sel);
    assign ext_push = wr_en & (dsel == DSEL_EXT);
    assign stall    = ext_full;

    // A/B register capture; DSEL_NONE and DSEL_EXT leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg <= REG_RST;
            reg_a <= REG_RST;
        end else if (wr_en) begin
            if (dsel == DSEL_BREG) b_reg <= b_bus;
            if (dsel == DSEL_AREG) reg_a <= b_bus;
        end
    end

    ext_out_skid #(
        .DATA_W(DATA_W)
    ) u_ext_out_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ext_push),
        .push_data(b_bus),
        .ready    (ext_out_ready),
        .valid    (ext_out_valid),
        .data     (ext_out_data),
        .full     (ext_full)
    );

`ifdef BUS_WRITEBACK_OVF_CNT_EN
    // Count pushes dropped while the buffer is full, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= 8'd0;
        end else if (ext_push && ext_full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_writeback.sv
// Self-checking bench for bus_writeback with a queue-based reference model.
module tb_bus_writeback;

    logic       clk;
    logic       rst_n;
    logic [7:0] b_bus;
    logic       wr_en;
    logic [1:0] d_sel;
    logic [7:0] b_reg;
    logic [7:0] reg_a;
    logic [7:0] ext_out_data;
    logic       ext_out_valid;
    logic       ext_out_ready;
    logic       stall;
`ifdef BUS_WRITEBACK_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [7:0] exp_q[$];
    logic [7:0] m_b;
    logic [7:0] m_a;
    logic [7:0] m_last;
    int         m_ovf;

    bus_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .b_bus        (b_bus),
        .wr_en        (wr_en),
        .d_sel        (d_sel),
        .b_reg        (b_reg),
        .reg_a        (reg_a),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready),
        .stall        (stall)
`ifdef BUS_WRITEBACK_OVF_CNT_EN
        ,
        .ovf_cnt      (ovf_cnt)
`endif
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_b    = 8'h00;
        m_a    = 8'h00;
        m_last = 8'h00;
        m_ovf  = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // then move to 1 time unit after the rising edge.
    task automatic cycle();
        bit pop;
        bit push_req;
        bit was_full;
        pop      = (exp_q.size() > 0) && ext_out_ready;
        push_req = wr_en && (d_sel == 2'b11);
        was_full = (exp_q.size() == 2);
        if (wr_en && d_sel == 2'b00) m_b = b_bus;
        if (wr_en && d_sel == 2'b01) m_a = b_bus;
        if (pop) void'(exp_q.pop_front());
        if (push_req) begin
            if (was_full) begin
                if (m_ovf < 255) m_ovf++;
            end else begin
                exp_q.push_back(b_bus);
            end
        end
        if (exp_q.size() > 0) m_last = exp_q[0];
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [7:0] val, input logic rdy);
        wr_en         = we;
        d_sel         = sel;
        b_bus         = val;
        ext_out_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (b_reg !== 8'h00) begin bad++; $display("FAIL reset_b_reg actual=%h required=%h", b_reg, 8'h00); end
        total++; if (reg_a !== 8'h00) begin bad++; $display("FAIL reset_reg_a actual=%h required=%h", reg_a, 8'h00); end
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", ext_out_valid); end
        total++; if (ext_out_data !== 8'h00) begin bad++; $display("FAIL reset_data actual=%h required=00", ext_out_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall actual=%b required=0", stall); end
`ifdef BUS_WRITEBACK_OVF_CNT_EN
        total++; if (ovf_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovf actual=%0d required=0", ovf_cnt); end
`endif
    endtask

    task automatic test_breg();
        drive(1'b1, 2'b00, 8'h3C, 1'b0);
        #1;
        total++; if (b_reg !== 8'h00) begin bad++; $display("FAIL breg_no_bypass actual=%h required=00", b_reg); end
        cycle();
        total++; if (b_reg !== 8'h3C) begin bad++; $display("FAIL breg_write actual=%h required=3c", b_reg); end
        total++; if (reg_a !== 8'h00) begin bad++; $display("FAIL breg_areg_untouched actual=%h required=00", reg_a); end
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL breg_no_ext actual=%b required=0", ext_out_valid); end
    endtask

    task automatic test_areg_none();
        drive(1'b1, 2'b01, 8'hA5, 1'b0);
        cycle();
        drive(1'b1, 2'b10, 8'hFF, 1'b0);
        cycle();
        total++; if (reg_a !== 8'hA5) begin bad++; $display("FAIL areg_write actual=%h required=a5", reg_a); end
        total++; if (b_reg !== 8'h3C) begin bad++; $display("FAIL none_b_reg actual=%h required=3c", b_reg); end
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL none_no_ext actual=%b required=0", ext_out_valid); end
        drive(1'b0, 2'b00, 8'h77, 1'b0);
        cycle();
        drive(1'b0, 2'b11, 8'h78, 1'b0);
        cycle();
        total++; if (b_reg !== 8'h3C) begin bad++; $display("FAIL wr_en_low_b_reg actual=%h required=3c", b_reg); end
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL wr_en_low_ext actual=%b required=0", ext_out_valid); end
    endtask

    task automatic test_ext_fill_drain();
        drive(1'b1, 2'b11, 8'h96, 1'b0);
        cycle();
        total++; if (ext_out_valid !== 1'b1 || ext_out_data !== 8'h96) begin bad++; $display("FAIL fill_first actual=%b/%h required=1/96", ext_out_valid, ext_out_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fill_first_stall actual=%b required=0", stall); end
        drive(1'b1, 2'b11, 8'h11, 1'b0);
        cycle();
        total++; if (stall !== 1'b1 || ext_out_data !== 8'h96) begin bad++; $display("FAIL fill_full actual=%b/%h required=1/96", stall, ext_out_data); end
        drive(1'b1, 2'b11, 8'h22, 1'b0);
        cycle();
        total++; if (stall !== 1'b1 || ext_out_data !== 8'h96) begin bad++; $display("FAIL drop_push actual=%b/%h required=1/96", stall, ext_out_data); end
`ifdef BUS_WRITEBACK_OVF_CNT_EN
        total++; if (ovf_cnt !== 8'd1) begin bad++; $display("FAIL drop_ovf actual=%0d required=1", ovf_cnt); end
`endif
        drive(1'b0, 2'b00, 8'h00, 1'b1);
        cycle();
        total++; if (ext_out_valid !== 1'b1 || ext_out_data !== 8'h11) begin bad++; $display("FAIL drain_second actual=%b/%h required=1/11", ext_out_valid, ext_out_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL drain_stall actual=%b required=0", stall); end
        cycle();
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty actual=%b required=0", ext_out_valid); end
        total++; if (ext_out_data !== 8'h11) begin bad++; $display("FAIL drain_hold_last actual=%h required=11", ext_out_data); end
    endtask

    task automatic test_push_pop_same();
        drive(1'b1, 2'b11, 8'h01, 1'b0);
        cycle();
        drive(1'b1, 2'b11, 8'h02, 1'b1);
        cycle();
        total++; if (ext_out_valid !== 1'b1 || ext_out_data !== 8'h02) begin bad++; $display("FAIL push_pop_data actual=%b/%h required=1/02", ext_out_valid, ext_out_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL push_pop_stall actual=%b required=0", stall); end
        drive(1'b0, 2'b00, 8'h00, 1'b1);
        cycle();
        total++; if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL push_pop_empty actual=%b required=0", ext_out_valid); end
    endtask

    task automatic test_hold_stable();
        drive(1'b1, 2'b11, 8'h5A, 1'b0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive(1'b1, 2'b11, 8'hC3, 1'b0);
            else drive(1'b0, 2'b00, 8'h00, 1'b0);
            cycle();
            total++; if (ext_out_valid !== 1'b1 || ext_out_data !== 8'h5A) begin bad++; $display("FAIL hold_stable[%0d] actual=%b/%h required=1/5a", i, ext_out_valid, ext_out_data); end
        end
        drive(1'b0, 2'b00, 8'h00, 1'b1);
        cycle();
        total++; if (ext_out_data !== 8'hC3) begin bad++; $display("FAIL hold_then_skid actual=%h required=c3", ext_out_data); end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 1)));
            cycle();
            total++;
            if (b_reg !== m_b || reg_a !== m_a || ext_out_valid !== (exp_q.size() > 0)
                || ext_out_data !== m_last || stall !== (exp_q.size() == 2)) begin
                bad++;
                $display("FAIL random[%0d] actual b=%h a=%h v=%b d=%h s=%b required b=%h a=%h v=%b d=%h s=%b",
                         i, b_reg, reg_a, ext_out_valid, ext_out_data, stall,
                         m_b, m_a, (exp_q.size() > 0), m_last, (exp_q.size() == 2));
            end
`ifdef BUS_WRITEBACK_OVF_CNT_EN
            total++; if (ovf_cnt !== 8'(m_ovf)) begin bad++; $display("FAIL random_ovf[%0d] actual=%0d required=%0d", i, ovf_cnt, m_ovf); end
`endif
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 2'b00, 8'h00, 1'b1);
        repeat (3) cycle();
        drive(1'b1, 2'b00, 8'h4D, 1'b0);
        cycle();
        drive(1'b1, 2'b11, 8'hE1, 1'b0);
        cycle();
        drive(1'b1, 2'b11, 8'hE2, 1'b0);
        cycle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL async_pre_full actual=%b required=1", stall); end
        drive(1'b0, 2'b00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ext_out_valid !== 1'b0 || stall !== 1'b0 || ext_out_data !== 8'h00) begin bad++; $display("FAIL async_clear_ext actual=%b/%b/%h required=0/0/00", ext_out_valid, stall, ext_out_data); end
        total++; if (b_reg !== 8'h00 || reg_a !== 8'h00) begin bad++; $display("FAIL async_clear_regs actual=%h/%h required=00/00", b_reg, reg_a); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle();
        total++; if (ext_out_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL async_after_release actual=%b/%b required=0/0", ext_out_valid, stall); end
        total++; if (b_reg !== 8'h00 || reg_a !== 8'h00) begin bad++; $display("FAIL async_after_regs actual=%h/%h required=00/00", b_reg, reg_a); end
    endtask

    initial begin
        test_reset();
        test_breg();
        test_areg_none();
        test_ext_fill_drain();
        test_push_pop_same();
        test_hold_stable();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
